// File: rtl/perm_round_ctrl_pkg.sv
// Shared definitions for the key-controlled byte-permutation round sequencer.
package perm_round_ctrl_pkg;

  localparam int unsigned BLOCK_W        = 128;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned LANES          = BLOCK_W / BYTE_W;
  localparam int unsigned RND_W          = 5;
  localparam int unsigned DEFAULT_ROUNDS = 8;

  // Byte-lane indices; lane 15 is the most significant byte of the block.
  localparam int unsigned LANE_A0 = 15;
  localparam int unsigned LANE_A1 = 14;
  localparam int unsigned LANE_A2 = 13;
  localparam int unsigned LANE_A3 = 12;
  localparam int unsigned LANE_B0 = 11;
  localparam int unsigned LANE_B1 = 10;
  localparam int unsigned LANE_B2 = 9;
  localparam int unsigned LANE_B3 = 8;
  localparam int unsigned LANE_C0 = 7;
  localparam int unsigned LANE_C1 = 6;
  localparam int unsigned LANE_C2 = 5;
  localparam int unsigned LANE_C3 = 4;
  localparam int unsigned LANE_D0 = 3;
  localparam int unsigned LANE_D1 = 2;
  localparam int unsigned LANE_D2 = 1;
  localparam int unsigned LANE_D3 = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

endpackage

// File: rtl/perm_round_ctrl_unpack.sv
// Combinational split/join between a 128-bit block word and the 16 byte ports of the permutation stage.
module perm_state_unpack
  import perm_round_ctrl_pkg::*;
(
  input  logic [BLOCK_W-1:0]           split_word,
  output logic [LANES-1:0][BYTE_W-1:0] split_lanes,
  input  logic [LANES-1:0][BYTE_W-1:0] join_lanes,
  output logic [BLOCK_W-1:0]           join_word
);

  assign split_lanes[LANE_A0] = split_word[LANE_A0*BYTE_W +: BYTE_W];
  assign split_lanes[LANE_A1] = split_word[LANE_A1*BYTE_W +: BYTE_W];
  assign split_lanes[LANE_A2] = split_word[LANE_A2*BYTE_W +: BYTE_W];
  assign split_lanes[LANE_A3] = split_word[LANE_A3*BYTE_W +: BYTE_W];
  assign split_lanes[LANE_B0] = split_word[LANE_B0*BYTE_W +: BYTE_W];
  assign split_lanes[LANE_B1] = split_word[LANE_B1*BYTE_W +: BYTE_W];
  assign split_lanes[LANE_B2] = split_word[LANE_B2*BYTE_W +: BYTE_W];
  assign split_lanes[LANE_B3] = split_word[LANE_B3*BYTE_W +: BYTE_W];
  assign split_lanes[LANE_C0] = split_word[LANE_C0*BYTE_W +: BYTE_W];
  assign split_lanes[LANE_C1] = split_word[LANE_C1*BYTE_W +: BYTE_W];
  assign split_lanes[LANE_C2] = split_word[LANE_C2*BYTE_W +: BYTE_W];
  assign split_lanes[LANE_C3] = split_word[LANE_C3*BYTE_W +: BYTE_W];
  assign split_lanes[LANE_D0] = split_word[LANE_D0*BYTE_W +: BYTE_W];
  assign split_lanes[LANE_D1] = split_word[LANE_D1*BYTE_W +: BYTE_W];
  assign split_lanes[LANE_D2] = split_word[LANE_D2*BYTE_W +: BYTE_W];
  assign split_lanes[LANE_D3] = split_word[LANE_D3*BYTE_W +: BYTE_W];

  // Packed lane array already follows the a0..d3 MSB-first block packing.
  assign join_word = join_lanes;

endmodule

// File: rtl/perm_round_ctrl.sv
// Multi-round sequencer: accepts a block and key, iterates the external permutation stage ROUNDS times, returns the result.
module perm_round_ctrl
  import perm_round_ctrl_pkg::*;
#(
  parameter int unsigned ROUNDS = DEFAULT_ROUNDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BLOCK_W-1:0]    in_data,
  input  logic [2*ROUNDS-1:0]   in_key,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BLOCK_W-1:0]    out_data,
  input  logic                  flush,
  output logic                  busy,
  output logic [RND_W-1:0]      round,
  output logic                  stage_en,
  output logic                  stage_k0,
  output logic                  stage_k1,
  output logic [BLOCK_W-1:0]    stage_in,
  input  logic [BLOCK_W-1:0]    stage_out
);

  localparam int unsigned       KEY_W    = 2 * ROUNDS;
  localparam logic [RND_W-1:0]  LAST_RND = RND_W'(ROUNDS - 1);

  fsm_e               fsm_q, fsm_d;
  logic [BLOCK_W-1:0] state_q, state_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [RND_W-1:0]   rnd_q, rnd_d;

  logic [LANES-1:0][BYTE_W-1:0] drive_lanes;
  logic [LANES-1:0][BYTE_W-1:0] sample_lanes;
  logic [BLOCK_W-1:0]           sample_word;

  // Registered state feeds the stage byte ports; the stage result comes back through the same packing.
  perm_state_unpack u_drive (
    .split_word  (state_q),
    .split_lanes (drive_lanes),
    .join_lanes  (drive_lanes),
    .join_word   (stage_in)
  );

  perm_state_unpack u_sample (
    .split_word  (stage_out),
    .split_lanes (sample_lanes),
    .join_lanes  (sample_lanes),
    .join_word   (sample_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    key_d     = key_q;
    rnd_d     = rnd_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    stage_en  = 1'b0;
    stage_k0  = 1'b0;
    stage_k1  = 1'b0;

    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          fsm_d   = RUN;
          state_d = in_data;
          key_d   = in_key;
          rnd_d   = '0;
        end
      end

      RUN: begin
        stage_en = 1'b1;
        stage_k0 = key_q[0];
        stage_k1 = key_q[1];
        if (flush) begin
          fsm_d   = IDLE;
          state_d = '0;
          key_d   = '0;
          rnd_d   = '0;
        end else begin
          state_d = sample_word;
          key_d   = key_q >> 2;
          rnd_d   = rnd_q + RND_W'(1);
          if (rnd_q == LAST_RND) begin
            fsm_d = DONE;
          end
        end
      end

      DONE: begin
        out_valid = 1'b1;
        out_data  = state_q;
        // Abort takes priority over a coincident downstream accept.
        if (flush) begin
          fsm_d   = IDLE;
          state_d = '0;
          key_d   = '0;
          rnd_d   = '0;
        end else if (out_ready) begin
          fsm_d = IDLE;
          rnd_d = '0;
        end
      end

      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  assign busy  = (fsm_q != IDLE);
  assign round = rnd_q;

  a_out_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

  a_rnd_range: assert property (@(posedge clk) disable iff (rst)
    (fsm_q == RUN) |-> (rnd_q <= LAST_RND));

endmodule

// File: tb/tb_perm_round_ctrl.sv
// Self-checking bench for perm_round_ctrl with ROUNDS=4 and a rotate-left-by-byte stub stage.
module tb_perm_round_ctrl;

  localparam int R  = 4;
  localparam int KW = 2 * R;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_data;
  logic [KW-1:0] in_key;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_data;
  logic          flush;
  logic          busy;
  logic [4:0]    round;
  logic          stage_en;
  logic          stage_k0;
  logic          stage_k1;
  logic [127:0]  stage_in;
  logic [127:0]  stage_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  perm_round_ctrl #(.ROUNDS(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .busy      (busy),
    .round     (round),
    .stage_en  (stage_en),
    .stage_k0  (stage_k0),
    .stage_k1  (stage_k1),
    .stage_in  (stage_in),
    .stage_out (stage_out)
  );

  // Stub stage: rotate left one byte, then xor the two key bits into the low end.
  always_comb begin
    stage_out = '0;
    if (stage_en) stage_out = {stage_in[119:0], stage_in[127:120]} ^ {126'b0, stage_k1, stage_k0};
  end

  function automatic logic [127:0] ref_perm(input logic [127:0] d, input logic [KW-1:0] k);
    logic [127:0] s;
    s = d;
    for (int r = 0; r < R; r++) begin
      s = {s[119:0], s[127:120]};
      s[1:0] = s[1:0] ^ 2'(k >> (2 * r));
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Presents one block in an IDLE cycle and waits (bounded) for out_valid.
  task automatic run_block(input logic [127:0] d, input logic [KW-1:0] k,
                           output logic [127:0] res, output int lat, output int en_cnt);
    in_data  = d;
    in_key   = k;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = rand128();
    in_key   = KW'($urandom);
    lat      = 1;
    en_cnt   = 0;
    while (!out_valid && lat < 64) begin
      if (stage_en) en_cnt++;
      @(negedge clk);
      lat++;
    end
    res = out_data;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_data = rand128(); in_key = KW'($urandom);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy, round, stage_en, stage_k0, stage_k1} !== {1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctrl got rdy=%b vld=%b busy=%b rnd=%0d en=%b k=%b%b exp rdy=1 vld=0 busy=0 rnd=0 en=0 k=00",
               in_ready, out_valid, busy, round, stage_en, stage_k1, stage_k0);
    end
    checks++;
    if (out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++;
    if (stage_in !== 128'h0) begin errors++; $display("FAIL reset_stage_in got=%h exp=0", stage_in); end
  endtask

  task automatic test_sequencing();
    logic [127:0] res;
    int lat, en;
    out_ready = 1'b1;
    run_block(128'h000102030405060708090A0B0C0D0E0F, '0, res, lat, en);
    checks++;
    if (lat !== R + 1) begin errors++; $display("FAIL seq_latency got=%0d exp=%0d", lat, R + 1); end
    checks++;
    if (res !== 128'h0405060708090A0B0C0D0E0F00010203) begin
      errors++; $display("FAIL seq_data got=%h exp=0405060708090a0b0c0d0e0f00010203", res);
    end
    checks++;
    if (en !== R) begin errors++; $display("FAIL seq_stage_en_cycles got=%0d exp=%0d", en, R); end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL seq_after_handshake got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_key_order();
    logic [1:0]   exp_k [4];
    logic [1:0]   ks [$];
    int           rs [$];
    logic [127:0] d;
    int           c;
    exp_k = '{2'b00, 2'b01, 2'b10, 2'b11};
    d = rand128();
    out_ready = 1'b1;
    in_data = d; in_key = 8'hE4; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    c = 0;
    while (!out_valid && c < 40) begin
      if (stage_en) begin ks.push_back({stage_k1, stage_k0}); rs.push_back(int'(round)); end
      @(negedge clk);
      c++;
    end
    checks++;
    if (ks.size() != R) begin errors++; $display("FAIL key_round_count got=%0d exp=%0d", ks.size(), R); end
    for (int i = 0; i < ks.size() && i < R; i++) begin
      checks++;
      if (ks[i] !== exp_k[i] || rs[i] != i) begin
        errors++; $display("FAIL key_order[%0d] got k=%b rnd=%0d exp k=%b rnd=%0d", i, ks[i], rs[i], exp_k[i], i);
      end
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== ref_perm(d, 8'hE4)) begin
      errors++; $display("FAIL key_result got vld=%b data=%h exp vld=1 data=%h", out_valid, out_data, ref_perm(d, 8'hE4));
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [127:0] d, res, exp;
    logic [KW-1:0] k;
    int lat, en, hold;
    for (int n = 0; n < 16; n++) begin
      d = rand128();
      k = KW'($urandom);
      exp = ref_perm(d, k);
      out_ready = 1'b0;
      run_block(d, k, res, lat, en);
      checks++;
      if (res !== exp || lat !== R + 1) begin
        errors++; $display("FAIL rand[%0d] got data=%h lat=%0d exp data=%h lat=%0d", n, res, lat, exp, R + 1);
      end
      hold = $urandom_range(0, 3);
      repeat (hold) begin
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
          errors++; $display("FAIL rand_hold[%0d] got vld=%b data=%h exp vld=1 data=%h", n, out_valid, out_data, exp);
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL rand_release[%0d] got vld=%b rdy=%b exp vld=0 rdy=1", n, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] d, res, exp;
    logic [KW-1:0] k;
    int lat, en, bad;
    d = rand128(); k = KW'($urandom); exp = ref_perm(d, k);
    out_ready = 1'b0;
    run_block(d, k, res, lat, en);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i == 4);
      in_data  = rand128();
      if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles exp 0 (last vld=%b rdy=%b data=%h exp=%h)", bad, out_valid, in_ready, out_data, exp); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
    end
    bad = 0;
    repeat (3) begin @(negedge clk); if (busy !== 1'b0) bad++; end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_pulse_queued got busy in %0d cycles exp 0", bad); end
    d = rand128(); k = KW'($urandom);
    run_block(d, k, res, lat, en);
    checks++;
    if (res !== ref_perm(d, k)) begin errors++; $display("FAIL bp_next_block got=%h exp=%h", res, ref_perm(d, k)); end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic [127:0] d, res;
    logic [KW-1:0] k;
    int n, lat, en, seen;
    d = rand128(); k = KW'($urandom);
    out_ready = 1'b1;
    in_data = d; in_key = k; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!(stage_en && round == 5'd2) && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!(stage_en && round == 5'd2)) begin errors++; $display("FAIL flush_reach_round2 got en=%b rnd=%0d exp en=1 rnd=2", stage_en, round); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if ({busy, in_ready, out_valid, round} !== {1'b0, 1'b1, 1'b0, 5'd0} || stage_in !== 128'h0) begin
      errors++; $display("FAIL flush_idle got busy=%b rdy=%b vld=%b rnd=%0d sin=%h exp busy=0 rdy=1 vld=0 rnd=0 sin=0",
                         busy, in_ready, out_valid, round, stage_in);
    end
    seen = 0;
    repeat (8) begin @(negedge clk); if (out_valid) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL flush_no_valid got %0d valid cycles exp 0", seen); end
    d = rand128(); k = KW'($urandom);
    run_block(d, k, res, lat, en);
    checks++;
    if (res !== ref_perm(d, k) || lat !== R + 1) begin
      errors++; $display("FAIL flush_next_block got data=%h lat=%0d exp data=%h lat=%0d", res, lat, ref_perm(d, k), R + 1);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midrun();
    logic [127:0] d, res;
    logic [KW-1:0] k;
    int n, lat, en;
    d = rand128(); k = KW'($urandom);
    out_ready = 1'b0;
    in_data = d; in_key = k; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!(stage_en && round == 5'd1) && n < 20) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy, round, stage_en, stage_k0, stage_k1} !== {1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0}
        || out_data !== 128'h0 || stage_in !== 128'h0) begin
      errors++; $display("FAIL rst_midrun got rdy=%b vld=%b busy=%b rnd=%0d en=%b k=%b%b out=%h sin=%h exp reset values",
                         in_ready, out_valid, busy, round, stage_en, stage_k1, stage_k0, out_data, stage_in);
    end
    d = rand128(); k = KW'($urandom);
    run_block(d, k, res, lat, en);
    checks++;
    if (res !== ref_perm(d, k) || en !== R) begin
      errors++; $display("FAIL rst_next_block got data=%h en=%0d exp data=%h en=%0d", res, en, ref_perm(d, k), R);
    end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_flush_vs_ready();
    logic [127:0] d, res;
    logic [KW-1:0] k;
    int lat, en, falls, rises;
    logic prev;
    d = rand128(); k = KW'($urandom);
    out_ready = 1'b0;
    run_block(d, k, res, lat, en);
    checks++;
    if (out_valid !== 1'b1 || res !== ref_perm(d, k)) begin
      errors++; $display("FAIL fvr_done got vld=%b data=%h exp vld=1 data=%h", out_valid, res, ref_perm(d, k));
    end
    prev = out_valid;
    falls = 0; rises = 0;
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 128'h0 || stage_in !== 128'h0 || round !== 5'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL fvr_cleared got vld=%b out=%h sin=%h rnd=%0d rdy=%b exp vld=0 out=0 sin=0 rnd=0 rdy=1",
                         out_valid, out_data, stage_in, round, in_ready);
    end
    for (int i = 0; i < 6; i++) begin
      if (prev && !out_valid) falls++;
      if (!prev && out_valid) rises++;
      prev = out_valid;
      @(negedge clk);
    end
    checks++;
    if (falls != 1 || rises != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL fvr_transitions got falls=%0d rises=%0d busy=%b exp falls=1 rises=0 busy=0", falls, rises, busy);
    end
  endtask

  initial begin
    test_reset();
    test_sequencing();
    test_key_order();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_midrun();
    test_flush_vs_ready();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/perm_round_ctrl.md
# perm_round_ctrl

Multi-round sequencer for the key-controlled byte-permutation stage of the crypt datapath. It accepts one 128-bit block and a round key over a valid/ready handshake. It then drives the combinational permutation stage once per cycle for ROUNDS rounds, feeding back the registered state and presenting two fresh key bits each round. It returns the result over a second valid/ready handshake and sits between the block input buffer and the next crypt stage.

## Interface
- ROUNDS, 8, rounds per block; legal range 1..32.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  controller can accept a block.
- in_data  in  128  block; bytes a0..a3,b0..b3,c0..c3,d0..d3, from MSB to LSB.
- in_key  in  2*ROUNDS  round key; round r uses k0=in_key[2r], k1=in_key[2r+1].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  128  result block, same byte packing as in_data.
- flush  in  1  abort the current block.
- busy  out  1  high in RUN or DONE.
- round  out  5  current round index.
- stage_en  out  1  permutation stage Enable.
- stage_k0, stage_k1  out  1 each  permutation select bits.
- stage_in  out  128  state driven into the stage.
- stage_out  in  128  stage result, same packing.

## Operation
- FSM states: IDLE, RUN, DONE. Registers: state_q[127:0], key_q[2*ROUNDS-1:0], rnd_q[4:0].
- **IDLE:**
  - in_ready=1.
  - On in_valid&&in_ready: state_q<=in_data, key_q<=in_key, rnd_q<=0, go to RUN.
- **RUN:**
  - Outputs: stage_en=1, stage_in=state_q, {stage_k1,stage_k0}=key_q[1:0].
  - Each edge: state_q<=stage_out, key_q<=key_q>>2, rnd_q<=rnd_q+1.
  - When rnd_q==ROUNDS-1, that edge moves to DONE.
- **DONE:**
  - out_valid=1, out_data=state_q.
  - On out_ready: go to IDLE, clear rnd_q.
  - state_q holds until the handshake completes.
- **Output defaults:**
  - Outside RUN: stage_en=0, stage_k0=stage_k1=0, stage_in=state_q.
  - Outside DONE: out_data=0.
- **Status outputs:** round=rnd_q; busy=(state!=IDLE).
- **flush:** in RUN or DONE, the next edge goes to IDLE, clears rnd_q, state_q and key_q, and drops out_valid. Ignored in IDLE. flush wins over a simultaneous out_ready.
- **Input blocking:** in_ready is 0 in RUN and DONE. in_valid there is ignored, not queued.
- **Reset:** rst wins over everything, including mid-RUN. Next state is IDLE with all registers 0. Outputs after reset: in_ready=1, out_valid=0, out_data=0, busy=0, round=0, stage_en=0, stage_k0=0, stage_k1=0, stage_in=0.

## Timing
- Acceptance edge is E0. RUN occupies the cycles after E0 through E_ROUNDS. out_valid rises after edge E_ROUNDS.
- Latency from accept to out_valid is ROUNDS+1 cycles (9 for the default).
- Minimum initiation interval is ROUNDS+2 cycles: one cycle to accept, ROUNDS cycles of RUN, and at least one cycle in DONE.
- out_valid, once high, stays high with out_data stable until out_ready or flush.
- in_ready rises in the cycle after the DONE handshake. The next block is accepted no earlier than that cycle.
- The stage path is combinational: stage_in → stage_out → state_q in one cycle. There are no multicycle paths.
- ROUNDS=1: exactly one RUN cycle, then DONE.

## Structure
- Shared crypt package contents:
  - FSM state enum (IDLE/RUN/DONE).
  - BLOCK_W=128.
  - Byte-lane index constants for a0..d3.
  - Default ROUNDS.
- One sub-module, perm_state_unpack: combinational; splits and joins the 128-bit word into the 16 byte ports of the permutation stage. It is instantiated at the top level between the controller and the stage.
- The controller itself contains no permutation logic.

## Test plan
Bench setup: ROUNDS=4. A bench stub stage returns stage_out = rotl8(stage_in) ^ {126'b0,stage_k1,stage_k0}, and only when stage_en=1.
- **Sequencing:** in_data=0x000102030405060708090A0B0C0D0E0F, in_key=0x00, out_ready=1 → out_valid exactly 5 cycles after the accept edge; out_data=0x0405060708090A0B0C0D0E0F00010203.
- **Key order:** in_key=0xE4 → {k1,k0} sampled in the RUN cycles = 00,01,10,11 in order; round output = 0,1,2,3 in those cycles; stage_en=1 for exactly 4 cycles.
- **Backpressure:** out_ready=0 for 10 cycles after out_valid → out_valid and out_data stable, in_ready=0, and an in_valid pulse is ignored. Raise out_ready → in_ready=1 next cycle.
- **Flush:** assert flush at round=2 → IDLE next cycle, out_valid never rises, busy=0. A new block then completes normally.
- **Reset mid-RUN:** rst at round=1 → next cycle all outputs at reset values. A following block yields correct results.
- **Flush vs out_ready:** flush and out_ready both high in DONE → flush wins; the state is cleared, and exactly one out_valid→0 transition occurs with no extra handshake.
